// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, default latencies, FSM states.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned MdMultCyclesDefault = 5;
  localparam int unsigned MdDivCyclesDefault  = 10;
  localparam int unsigned MdCntWidth          = 5;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request and HI/LO result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             md_stall;

  modport master (
    output start, op, a, b, cancel,
    input  busy, hi, lo, md_stall
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, hi, lo, md_stall
  );
endinterface

// File: rtl/mult_div_unit_md_divider.sv
// Combinational signed/unsigned divider: truncating quotient, remainder takes the dividend's sign.
module md_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic             neg_a, neg_b, overflow;
  logic [WIDTH-1:0] mag_a, mag_b, safe_b, uq, ur;

  assign neg_a = is_signed & dividend[WIDTH-1];
  assign neg_b = is_signed & divisor[WIDTH-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor : divisor;

  // Divide-by-zero results are discarded upstream; avoid an X-producing divide.
  assign safe_b = (mag_b == '0) ? WIDTH'(1) : mag_b;
  assign uq     = mag_a / safe_b;
  assign ur     = mag_a % safe_b;

  assign overflow = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  assign quotient  = overflow ? dividend : ((neg_a ^ neg_b) ? -uq : uq);
  assign remainder = overflow ? '0 : (neg_a ? -ur : ur);
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit owning the HI/LO registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = MdMultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = MdDivCyclesDefault
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave md
);
  localparam logic [MdCntWidth-1:0] MultLat = MdCntWidth'(MULT_CYCLES);
  localparam logic [MdCntWidth-1:0] DivLat  = MdCntWidth'(DIV_CYCLES);

  md_state_e             state_q, state_d;
  logic [MdCntWidth-1:0] cnt_q, cnt_d;
  md_op_e                op_q, op_d;
  logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;

  logic                  is_mult, start_long;
  logic [2*WIDTH-1:0]    mult_a, mult_b, product;
  logic [WIDTH-1:0]      quotient, remainder;

  // Results are computed only from captured operands, so a/b/op never reach hi/lo directly.
  assign is_mult = (op_q == MdMult) || (op_q == MdMultu);
  assign mult_a  = {{WIDTH{(op_q == MdMult) & a_q[WIDTH-1]}}, a_q};
  assign mult_b  = {{WIDTH{(op_q == MdMult) & b_q[WIDTH-1]}}, b_q};
  assign product = mult_a * mult_b;

  md_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .dividend (a_q),
    .divisor  (b_q),
    .is_signed(op_q == MdDiv),
    .quotient (quotient),
    .remainder(remainder)
  );

  assign start_long = md.start && (md.op >= MdMult) && (md.op <= MdDivu);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md.start && !md.cancel) begin
          case (md.op)
            MdMult, MdMultu, MdDiv, MdDivu: begin
              state_d = StRun;
              op_d    = md_op_e'(md.op);
              a_d     = md.a;
              b_d     = md.b;
              cnt_d   = (md.op <= MdMultu) ? MultLat : DivLat;
            end
            MdMthi:  hi_d = md.a;
            MdMtlo:  lo_d = md.a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (md.cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            state_d = StIdle;
            if (is_mult) begin
              {hi_d, lo_d} = product;
            end else if (b_q != '0) begin
              hi_d = remainder;
              lo_d = quotient;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MdNone;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy     = (state_q == StRun);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = md.busy | start_long;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked when busy drops.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  exp_t sb_q[$];
  logic prev_busy = 1'b0;

  mult_div_unit_if #(.WIDTH(32)) md0 ();
  mult_div_unit_if #(.WIDTH(32)) md1 ();

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk  (clk),
    .reset(reset),
    .md   (md0)
  );

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .md   (md1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; drives a request that the next edge samples.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit chk_stall);
    md0.start = 1'b1;
    md0.op    = op;
    md0.a     = a;
    md0.b     = b;
    if (chk_stall) begin
      #1;
      check("md_stall_on_start", md0.md_stall, 1);
      check("busy_before_capture", md0.busy, 0);
    end
    @(posedge clk); #1;
    md0.start = 1'b0;
    md0.op    = MdNone;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (md0.busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every busy 1->0 transition is a completion (or abort) to score.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_busy && md0.busy !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no completion",
                   md0.hi, md0.lo);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, md0.hi, e.hi);
          check({e.name, "_lo"}, md0.lo, e.lo);
        end
      end
      prev_busy = (md0.busy === 1'b1);
    end
  end

  initial begin
    md0.start = 0; md0.op = MdNone; md0.a = 0; md0.b = 0; md0.cancel = 0;
    md1.start = 0; md1.op = MdNone; md1.a = 0; md1.b = 0; md1.cancel = 0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_busy", md0.busy, 0);
    check("reset_hi", md0.hi, 0);
    check("reset_lo", md0.lo, 0);
    check("reset_md_stall", md0.md_stall, 0);

    push("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(MdMult, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_idle(n);
    check("mult_busy_cycles", n, 5);

    push("divu_7_2", 32'd1, 32'd3);
    issue(MdDivu, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    check("divu_busy_cycles", n, 10);

    push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(MdDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);

    push("div_overflow", 32'h0, 32'h8000_0000);
    issue(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);

    issue(MdMthi, 32'h11, 32'h0, 1'b0);
    check("mthi_no_busy", md0.busy, 0);
    check("mthi_hi", md0.hi, 32'h11);
    issue(MdMtlo, 32'h22, 32'h0, 1'b0);
    check("mtlo_lo", md0.lo, 32'h22);
    check("mtlo_hi_kept", md0.hi, 32'h11);

    push("div_by_zero", 32'h11, 32'h22);
    issue(MdDiv, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    check("div0_busy_cycles", n, 10);

    // MULTU with an MTLO arriving while busy; the MTLO must be dropped.
    push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    md0.start = 1'b1; md0.op = MdMtlo; md0.a = 32'd5;
    #1;
    check("mtlo_busy_stall", md0.md_stall, 1);
    @(posedge clk); #1;
    md0.start = 1'b0; md0.op = MdNone;
    check("mtlo_busy_still_busy", md0.busy, 1);
    wait_idle(n);

    push("mult_cancelled", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(MdMult, 32'd9, 32'd9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    md0.cancel = 1'b1;
    @(posedge clk); #1;
    md0.cancel = 1'b0;
    check("cancel_busy_drop", md0.busy, 0);

    push("mult_4x5", 32'h0, 32'd20);
    issue(MdMult, 32'd4, 32'd5, 1'b0);
    wait_idle(n);

    md0.cancel = 1'b1;
    issue(MdMult, 32'd3, 32'd3, 1'b0);
    check("cancel_start_no_busy", md0.busy, 0);
    issue(MdMthi, 32'hAB, 32'd0, 1'b0);
    md0.cancel = 1'b0;
    check("cancel_mthi_hi", md0.hi, 32'h0);
    check("cancel_start_lo", md0.lo, 32'd20);

    issue(MdNone, 32'h55, 32'h55, 1'b0);
    issue(3'd7, 32'h66, 32'h66, 1'b0);
    check("nop_busy", md0.busy, 0);
    check("nop_hi", md0.hi, 32'h0);
    check("nop_lo", md0.lo, 32'd20);

    push("reset_mid_div", 32'h0, 32'h0);
    issue(MdDiv, 32'd100, 32'd7, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", md0.busy, 1);
    reset = 1'b1;
    #1;
    check("reset_async_busy", md0.busy, 0);
    check("reset_async_hi", md0.hi, 0);
    check("reset_async_lo", md0.lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    push("multu_after_reset", 32'h0, 32'd9);
    issue(MdMultu, 32'd3, 32'd3, 1'b0);
    wait_idle(n);
    check("after_reset_busy_cycles", n, 5);

    // Single-cycle latency instance.
    md1.start = 1'b1; md1.op = MdMult; md1.a = 32'd6; md1.b = 32'd7;
    @(posedge clk); #1;
    md1.start = 1'b0; md1.op = MdNone;
    check("fast_mult_busy", md1.busy, 1);
    @(posedge clk); #1;
    check("fast_mult_idle", md1.busy, 0);
    check("fast_mult_hi", md1.hi, 0);
    check("fast_mult_lo", md1.lo, 32'd42);
    md1.start = 1'b1; md1.op = MdDiv; md1.a = 32'd20; md1.b = 32'd6;
    @(posedge clk); #1;
    md1.start = 1'b0; md1.op = MdNone;
    check("fast_div_busy", md1.busy, 1);
    @(posedge clk); #1;
    check("fast_div_idle", md1.busy, 0);
    check("fast_div_hi", md1.hi, 32'd2);
    check("fast_div_lo", md1.lo, 32'd3);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 Parameter MULT_CYCLES, default 5: multiply latency in cycles; legal range 1..31.
REQ-003 Parameter DIV_CYCLES, default 10: divide latency in cycles; legal range 1..31.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  E-stage request qualifier; op is sampled only when start=1.
REQ-007 op  input  3  operation: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
REQ-008 a  input  WIDTH  rs operand, already forwarded.
REQ-009 b  input  WIDTH  rt operand, already forwarded.
REQ-010 cancel  input  1  aborts the in-flight operation; reserved for exception flush.
REQ-011 busy  output  1  operation in flight.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.
REQ-014 md_stall  output  1  combinational (busy | (start & op in MULT..DIVU)); consumed by the hazard unit.

Function
REQ-015 The unit is an FSM with states IDLE and RUN plus a 5-bit down-counter.
REQ-016 In IDLE, start=1 with op in MULT..DIVU captures a and b, sets the counter to the op latency, and enters RUN at that edge.
REQ-017 busy is 1 exactly while in RUN, i.e. for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge.
REQ-018 In RUN the counter decrements each cycle; at the edge where it reaches 0, hi/lo load the result and the FSM returns to IDLE in the same edge.
REQ-019 MULT: {hi,lo} = signed a*b, full 2*WIDTH product. MULTU: the same, unsigned.
REQ-020 DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign. DIVU: the same, unsigned.
REQ-021 DIV with a = most-negative and b = -1 yields lo = most-negative and hi = 0.
REQ-022 Divide by zero (b=0) still runs the full DIV_CYCLES with busy high; hi and lo keep their prior values.
REQ-023 MTHI and MTLO with start=1 in IDLE write a into hi or lo at that edge, with no busy.
REQ-024 start=1 while busy=1 is ignored: no capture, no write, and the counter is undisturbed. The hazard unit holds the instruction in D via md_stall.
REQ-025 cancel=1 in RUN returns to IDLE at the next edge; hi and lo are unchanged.
REQ-026 cancel=1 on the same edge as a start capture wins: no operation is started.
REQ-027 cancel=1 on the same edge as an MTHI/MTLO start suppresses the write.
REQ-028 op=NONE, or an unlisted code, with start=1 has no effect.
REQ-029 hi and lo are registered outputs. A subsequent MFHI/MFLO reads them directly and needs no forwarding from this unit.

Reset
REQ-030 Reset asserted at any time, including mid-RUN, forces IDLE, counter=0, busy=0, hi=0, lo=0, and clears the captured operands, effective immediately.
REQ-031 The first edge after reset deasserts accepts a new start.

Structure
REQ-032 The op encodings (NONE..MTLO) and the default latencies live in the shared constants package, alongside the existing ALU/branch codes.
REQ-033 One sub-module, md_divider (signed/unsigned quotient and remainder, including the REQ-021 special case), is instantiated once. Multiplication stays inline.
REQ-034 No combinational path runs from a, b or op to hi or lo.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-036 DIVU a=7, b=2 -> busy for 10 cycles, then lo=3 and hi=1; DIV a=-7, b=2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000 and hi=0; DIV b=0 with prior hi=0x11, lo=0x22 -> values unchanged after 10 cycles.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF started; MTLO a=5 issued at cycle 2 while busy -> ignored and md_stall=1; after completion hi=0xFFFFFFFE and lo=0x00000001.
REQ-039 MULT started, then cancel at cycle 3 -> busy drops the next cycle with hi/lo unchanged; a second MULT 4*5 then gives lo=20.
REQ-040 reset pulsed mid-DIV (cycle 4) -> busy=0 and hi=lo=0 immediately; the bench rebuilds with MULT_CYCLES=1 and DIV_CYCLES=1 and checks single-cycle busy.
